// File: rtl/hazard_forward_unit.sv
// ID-stage hazard and forwarding controller.
// Keeps a shadow copy of the EX/MEM/WB destination fields and from it derives
// the forwarding mux selects, the load-use bubble and the memory-wait freeze.
// It also tracks stall statistics and a sticky memory-timeout flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow, all enables high
// LU_STALL | previous cycle inserted a load-use bubble (PC and IF/ID held)
// FREEZE   | previous cycle was frozen by mem_wait (whole pipe held)
module hazard_forward_unit #(
  parameter int CNT_W      = 16,
  parameter int MAX_FREEZE = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_rf_enable,
  input  logic             id_load,
  input  logic             mem_wait,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             nop_sel,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             pipe_enable,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MAX_F = CNT_W'(MAX_FREEZE);

  state_t           state_q;
  logic [CNT_W-1:0] freeze_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_q;

  logic             ex_rf_q, ex_ld_q, mem_rf_q, mem_ld_q, wb_rf_q, wb_ld_q;
  logic [4:0]       ex_dest_q, mem_dest_q, wb_dest_q;

  logic             lu;

  // A loading EX entry is skipped here: its data is not ready, the load-use
  // stall covers it, and an older matching stage may still be selected.
  function automatic logic [1:0] fwd_pick(
    input logic       used,
    input logic [4:0] src,
    input logic       e_rf, input logic e_ld, input logic [4:0] e_dest,
    input logic       m_rf, input logic [4:0] m_dest,
    input logic       w_rf, input logic [4:0] w_dest
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (src != 5'd0)) begin
      if (e_rf && !e_ld && (e_dest == src))
        sel = 2'b01;
      else if (m_rf && (m_dest == src))
        sel = 2'b10;
      else if (w_rf && (w_dest == src))
        sel = 2'b11;
    end
    return sel;
  endfunction

  // Forwarding selects, load-use detection and enable priority.
  always_comb begin
    fwd_sel_a = fwd_pick(id_uses_rs, id_rs, ex_rf_q, ex_ld_q, ex_dest_q,
                         mem_rf_q, mem_dest_q, wb_rf_q, wb_dest_q);
    fwd_sel_b = fwd_pick(id_uses_rt, id_rt, ex_rf_q, ex_ld_q, ex_dest_q,
                         mem_rf_q, mem_dest_q, wb_rf_q, wb_dest_q);
    lu = ex_rf_q && ex_ld_q && (ex_dest_q != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_dest_q)) ||
          (id_uses_rt && (id_rt == ex_dest_q)));
    nop_sel     = 1'b0;
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    pipe_enable = 1'b1;
    if (mem_wait) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      pipe_enable = 1'b0;
    end else if (lu) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      nop_sel     = 1'b1;
    end
  end

  // Shadow pipe: shifts ID->EX->MEM->WB only when the real pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rf_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
      ex_dest_q  <= 5'd0;
      mem_rf_q   <= 1'b0;
      mem_ld_q   <= 1'b0;
      mem_dest_q <= 5'd0;
      wb_rf_q    <= 1'b0;
      wb_ld_q    <= 1'b0;
      wb_dest_q  <= 5'd0;
    end else if (pipe_enable) begin
      ex_rf_q    <= id_rf_enable & ~nop_sel;
      ex_ld_q    <= id_load & ~nop_sel;
      ex_dest_q  <= id_dest;
      mem_rf_q   <= ex_rf_q;
      mem_ld_q   <= ex_ld_q;
      mem_dest_q <= ex_dest_q;
      wb_rf_q    <= mem_rf_q;
      wb_ld_q    <= mem_ld_q;
      wb_dest_q  <= mem_dest_q;
    end
  end

  // State, freeze timer, sticky timeout and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      freeze_cnt_q <= '0;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (mem_wait)
        state_q <= FREEZE;
      else if (lu)
        state_q <= LU_STALL;
      else
        state_q <= RUN;

      // Leaving FREEZE (mem_wait low) clears the timer; it stops at MAX_F.
      if (!mem_wait) begin
        freeze_cnt_q <= '0;
      end else if ((state_q == FREEZE) && (freeze_cnt_q != MAX_F)) begin
        freeze_cnt_q <= freeze_cnt_q + 1'b1;
        if (freeze_cnt_q == (MAX_F - 1'b1))
          timeout_q <= 1'b1;
      end

      if (!pc_enable && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_cnt_q;
  assign mem_timeout = timeout_q;

  // Load bits of MEM/WB are carried for completeness of the shadow copy.
  logic unused_ok;
  assign unused_ok = mem_ld_q ^ wb_ld_q;

endmodule
